// File: rtl/downcounter_jk_pkg.sv
// Shared definitions for the JK-flip-flop down counter.
// J/K control encodings and the reset-value helper live here.
package downcounter_jk_pkg;

   localparam int unsigned MAX_WIDTH = 16;

   // Encoded as {j, k}.
   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TOG  = 2'b11
   } jk_e;

   // All-ones pattern for a counter of width w, right-aligned in MAX_WIDTH bits.
   function automatic logic [MAX_WIDTH-1:0] ones_val(input int unsigned w);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i < w) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous active-low reset and a
// parameterised reset value.
module jk_ff
   import downcounter_jk_pkg::*;
#(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its inputs from before the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RST_VAL;
      end else begin
         unique case (jk_e'({j, k}))
            JK_HOLD: q <= q;
            JK_RST:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            JK_TOG:  q <= ~q;
         endcase
      end
   end

endmodule

// File: rtl/downcounter_jk.sv
// Synchronous binary down counter from WIDTH JK flip-flops, with parallel
// load, count enable, combinational terminal count and a registered wrap pulse.
module downcounter_jk
   import downcounter_jk_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(ones_val(WIDTH));

   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;

   // A stage toggles on a decrement only when every lower bit is 0 (borrow).
   always_comb begin : stage_ctrl
      logic borrow;
      // NOTE: every signal driven here gets a default first so no latch
      // is inferred on the hold path.
      j      = '0;
      k      = '0;
      borrow = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (load) begin
            j[i] = load_val[i];
            k[i] = ~load_val[i];
         end else if (en) begin
            j[i] = borrow;
            k[i] = borrow;
         end
         borrow = borrow & ~Q[i];
      end
   end

   for (genvar g = 0; g < int'(WIDTH); g++) begin : g_stage
      jk_ff #(
         .RST_VAL(ALL_ONES[g])
      ) u_ff (
         .clk  (clk),
         .reset(reset),
         .j    (j[g]),
         .k    (k[g]),
         .q    (Q[g])
      );
   end

   assign tc = en & (Q == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrap <= 1'b0;
      end else begin
         wrap <= en & ~load & (Q == '0);
      end
   end

endmodule

// File: tb/tb_downcounter_jk.sv
// Bench for downcounter_jk: directed scenarios at WIDTH 3 and 4 plus a
// randomized run against a plain-arithmetic reference model.
module tb_downcounter_jk;

   logic       clk = 1'b0;
   logic       reset3, en3, load3;
   logic [2:0] load_val3;
   logic [2:0] q3;
   logic       tc3, wrap3;

   logic       reset4, en4, load4;
   logic [3:0] load_val4;
   logic [3:0] q4;
   logic       tc4, wrap4;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model for the WIDTH=3 instance.
   int exp_q3    = 7;
   int exp_wrap3 = 0;

   always #5 clk = ~clk;

   downcounter_jk #(.WIDTH(3)) dut3 (
      .clk(clk), .reset(reset3), .en(en3), .load(load3),
      .load_val(load_val3), .Q(q3), .tc(tc3), .wrap(wrap3)
   );

   downcounter_jk #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset4), .en(en4), .load(load4),
      .load_val(load_val4), .Q(q4), .tc(tc4), .wrap(wrap4)
   );

   // Advance the model by one edge using the current inputs, then wait for the
   // edge and settle 1 ns past it.
   task automatic tick3();
      exp_wrap3 = (en3 && !load3 && exp_q3 == 0) ? 1 : 0;
      if (load3)    exp_q3 = int'(load_val3);
      else if (en3) exp_q3 = (exp_q3 + 7) % 8;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset3 = 1'b0; en3 = 1'b1; load3 = 1'b0; load_val3 = '0;
      reset4 = 1'b0; en4 = 1'b0; load4 = 1'b0; load_val4 = '0;
      exp_q3 = 7; exp_wrap3 = 0;
      #10;
      n_total++; if (q3 !== 3'd7) $display("FAIL reset_q got=%0d want=7", q3); else n_pass++;
      n_total++; if (wrap3 !== 1'b0) $display("FAIL reset_wrap got=%b want=0", wrap3); else n_pass++;
      n_total++; if (tc3 !== 1'b0) $display("FAIL reset_tc got=%b want=0", tc3); else n_pass++;
      reset3 = 1'b1;
   endtask

   task automatic test_count();
      int seq [8] = '{6, 5, 4, 3, 2, 1, 0, 7};
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (tc3 !== (q3 == 3'd0))
            $display("FAIL count_tc step=%0d got=%b q=%0d", i, tc3, q3);
         else n_pass++;
         tick3();
         n_total++;
         if (q3 !== 3'(seq[i])) $display("FAIL count_q step=%0d got=%0d want=%0d", i, q3, seq[i]);
         else n_pass++;
         n_total++;
         if (wrap3 !== (i == 7)) $display("FAIL count_wrap step=%0d got=%b want=%b", i, wrap3, i == 7);
         else n_pass++;
      end
   endtask

   task automatic test_enable_gating();
      for (int i = 0; i < 3; i++) tick3();   // 7 -> 6 -> 5 -> 4
      n_total++; if (q3 !== 3'd4) $display("FAIL gate_pre got=%0d want=4", q3); else n_pass++;
      en3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick3();
         n_total++;
         if (q3 !== 3'd4 || tc3 !== 1'b0 || wrap3 !== 1'b0)
            $display("FAIL gate_hold cyc=%0d got q=%0d tc=%b wrap=%b want q=4 tc=0 wrap=0",
                     i, q3, tc3, wrap3);
         else n_pass++;
      end
      en3 = 1'b1;
      tick3();
      n_total++; if (q3 !== 3'd3) $display("FAIL gate_resume got=%0d want=3", q3); else n_pass++;
   endtask

   task automatic test_load();
      int seq [3] = '{1, 0, 7};
      for (int i = 0; i < 5; i++) tick3();   // 3 -> 2 -> 1 -> 0 -> 7 -> 6
      n_total++; if (q3 !== 3'd6) $display("FAIL load_pre got=%0d want=6", q3); else n_pass++;
      load3 = 1'b1; load_val3 = 3'd2;
      tick3();
      load3 = 1'b0; load_val3 = 3'd0;
      n_total++; if (q3 !== 3'd2) $display("FAIL load_q got=%0d want=2", q3); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick3();
         n_total++;
         if (q3 !== 3'(seq[i]) || wrap3 !== (i == 2))
            $display("FAIL load_count step=%0d got q=%0d wrap=%b want q=%0d wrap=%b",
                     i, q3, wrap3, seq[i], i == 2);
         else n_pass++;
      end
   endtask

   task automatic test_load_beats_wrap();
      for (int i = 0; i < 7; i++) tick3();   // 7 down to 0
      load3 = 1'b1; load_val3 = 3'd5;
      #1;
      n_total++;
      if (q3 !== 3'd0 || tc3 !== 1'b1) $display("FAIL lbw_pre got q=%0d tc=%b want q=0 tc=1", q3, tc3);
      else n_pass++;
      tick3();
      load3 = 1'b0; load_val3 = 3'd0;
      n_total++; if (q3 !== 3'd5) $display("FAIL lbw_q got=%0d want=5", q3); else n_pass++;
      n_total++; if (wrap3 !== 1'b0) $display("FAIL lbw_wrap got=%b want=0", wrap3); else n_pass++;
   endtask

   task automatic test_async_reset();
      tick3(); tick3();                      // 5 -> 4 -> 3
      n_total++; if (q3 !== 3'd3) $display("FAIL areset_pre got=%0d want=3", q3); else n_pass++;
      #4;                                    // mid-cycle, no clock edge
      reset3 = 1'b0;
      exp_q3 = 7; exp_wrap3 = 0;
      #1;
      n_total++;
      if (q3 !== 3'd7 || wrap3 !== 1'b0) $display("FAIL areset_now got q=%0d wrap=%b want q=7 wrap=0", q3, wrap3);
      else n_pass++;
      #1;
      reset3 = 1'b1; en3 = 1'b1;
      tick3();
      n_total++; if (q3 !== 3'd6) $display("FAIL areset_after got=%0d want=6", q3); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         en3       = ($urandom_range(0, 3) != 0);
         load3     = ($urandom_range(0, 7) == 0);
         load_val3 = 3'($urandom_range(0, 7));
         #1;
         n_total++;
         if (tc3 !== (en3 && exp_q3 == 0))
            $display("FAIL rand_tc cyc=%0d got=%b want=%b", i, tc3, en3 && exp_q3 == 0);
         else n_pass++;
         tick3();
         n_total++;
         if (q3 !== 3'(exp_q3) || wrap3 !== exp_wrap3[0])
            $display("FAIL rand_q cyc=%0d got q=%0d wrap=%b want q=%0d wrap=%0d",
                     i, q3, wrap3, exp_q3, exp_wrap3);
         else n_pass++;
      end
      en3 = 1'b0; load3 = 1'b0;
   endtask

   task automatic test_width4();
      int tc_cnt   = 0;
      int wrap_cnt = 0;
      n_total++; if (q4 !== 4'd15) $display("FAIL w4_reset got=%0d want=15", q4); else n_pass++;
      reset4 = 1'b1; en4 = 1'b1;
      #1;
      for (int i = 1; i <= 16; i++) begin
         if (tc4 === 1'b1) tc_cnt++;
         @(posedge clk);
         #1;
         if (wrap4 === 1'b1) wrap_cnt++;
         n_total++;
         if (q4 !== 4'((31 - i) % 16)) $display("FAIL w4_q step=%0d got=%0d want=%0d", i, q4, (31 - i) % 16);
         else n_pass++;
      end
      n_total++; if (tc_cnt != 1) $display("FAIL w4_tc_count got=%0d want=1", tc_cnt); else n_pass++;
      n_total++; if (wrap_cnt != 1) $display("FAIL w4_wrap_count got=%0d want=1", wrap_cnt); else n_pass++;
      n_total++; if (wrap4 !== 1'b1) $display("FAIL w4_wrap_final got=%b want=1", wrap4); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_count();
      test_enable_gating();
      test_load();
      test_load_beats_wrap();
      test_async_reset();
      test_random();
      test_width4();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/downcounter_jk.md
# downcounter_jk

Synchronous binary down counter built from JK flip-flops; the counting-direction counterpart to the team's JK up counter. Counts from all-ones toward zero, wraps, and supports parallel load and count enable. Used wherever a decrementing cycle/terminal count is needed, such as timeouts and countdown dividers. Produces a combinational terminal-count flag and a registered wrap pulse.

## Interface
- WIDTH, 3, counter width in bits (legal range 2..16)
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  asynchronous, active-low reset; asserted when 0
- en  input  1  count enable; decrement by 1 per rising edge while high
- load  input  1  synchronous parallel load; higher priority than en
- load_val  input  WIDTH  value captured on load
- Q  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational: en & (Q == 0)
- wrap  output  1  registered one-cycle pulse; high during the cycle after Q went 0 -> all-ones via counting

## Operation
- Reset (reset == 0): Q = {WIDTH{1'b1}} and wrap = 0 immediately, independent of clk. tc follows as en & (Q == 0), so it is 0 during reset.
- Priority per rising edge, with reset high: load > en > hold.
- load = 1: each stage i is driven with J = load_val[i] and K = ~load_val[i]. Q = load_val next cycle. wrap = 0 next cycle even if Q was 0 and en = 1.
- en = 1 and load = 0: stage i toggles, with J = K = 1, iff all lower bits Q[i-1:0] are 0. Stage 0 always toggles. Result is Q_next = Q - 1 mod 2^WIDTH.
- en = 0 and load = 0: all stages have J = K = 0; Q holds. wrap = 0 next cycle.
- Wrap: when Q == 0, en = 1 and load = 0, then Q_next = all-ones and wrap = 1 for exactly one cycle.
- wrap_next = en & ~load & (Q == 0). It is registered with the same async reset.
- Counting arithmetic is modulo 2^WIDTH. There are no saturation modes.
- Mid-operation reset: asserting reset at any point aborts the count. Q returns to all-ones and wrap clears. The first edge after release with en = 1 produces all-ones minus 1.

## Timing
- Latency: load and decrement are visible on Q 1 cycle after the sampling edge.
- tc is valid in the same cycle as Q. There is no register on tc. tc is high in the cycle before the wrap edge.
- wrap is high in the cycle where Q == all-ones after a counted wrap. It is aligned with Q, not with tc.
- Reset release: deassertion is asynchronous at the port. Callers release reset away from the clk edge; the block contains no internal reset synchronizer.
- All flops are rising-edge clk. The toggle-enable chain is combinational: an AND of the lower ~Q bits. The WIDTH-deep path is acceptable up to WIDTH = 16.

## Structure
- Sub-module jk_ff: a single JK flip-flop with async active-low reset and a parameterised reset value (preset to 1 or clear to 0). It implements J/K behaviour 00 hold, 01 reset, 10 set, 11 toggle.
- The top level generates WIDTH jk_ff instances, the per-stage J/K logic, tc, and the wrap register.
- Shared package entries:
  - JK encoding constants: JK_HOLD, JK_RST, JK_SET, JK_TOG.
  - A helper constant for the all-ones reset value, derived from WIDTH.
- There is no FSM beyond the counter state itself.

## Test plan
- Reset and count (WIDTH = 3): hold reset low for 10 ns, then release with en = 1 and a 10 ns clock.
  - Required: Q = 7 during reset.
  - Then Q = 6, 5, 4, 3, 2, 1, 0, 7.
  - tc = 1 only while Q = 0.
  - wrap = 1 only in the cycle Q = 7 after 0.
- Enable gating: with Q = 4, set en = 0 for 3 cycles, then en = 1.
  - Required: Q stays 4, tc = 0 and wrap = 0 for those cycles.
  - Then Q = 3.
- Parallel load: with Q = 6, pulse load = 1 and load_val = 2 for one cycle, with en = 1.
  - Required: Q = 2, then 1, 0, 7 with wrap = 1.
- Load beats wrap: with Q = 0 and en = 1, set load = 1 and load_val = 5.
  - Required: Q = 5 next cycle, wrap = 0. tc was 1 in the prior cycle.
- Async reset mid-count: with Q = 3, drop reset between clock edges.
  - Required: Q = 7 immediately, before the next edge, and wrap = 0.
  - After release with en = 1: Q = 6.
- WIDTH = 4 instance: reset, then 16 enabled cycles.
  - Required: Q goes 15 down to 0 and back to 15, with exactly one wrap pulse and exactly one tc-high cycle.
